// File: rtl/traffic_phase_ctrl.sv
// Multi-way traffic phase controller: rotating green/yellow/all-red phases,
// an optional pedestrian walk phase, and a night-mode flashing-yellow override.
module traffic_phase_ctrl #(
    parameter int NWAY     = 2,
    parameter int CNT_W    = 8,
    parameter int GREEN_T  = 10,
    parameter int YELLOW_T = 3,
    parameter int ALLRED_T = 1,
    parameter int WALK_T   = 6,
    parameter int FLASH_T  = 4,
    parameter int AW       = (NWAY > 1) ? $clog2(NWAY) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                night,
    input  logic                ped_req,
    output logic [3*NWAY-1:0]   light,
    output logic                walk,
    output logic [AW-1:0]       active_way,
    output logic                ped_pending
);

    typedef enum logic [2:0] {
        S_ALLRED = 3'd0,
        S_GREEN  = 3'd1,
        S_YELLOW = 3'd2,
        S_WALK   = 3'd3,
        S_FLASH  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_T - 1);
    localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_T - 1);
    localparam logic [AW-1:0]    LAST_WAY  = AW'(NWAY - 1);
    localparam logic [AW-1:0]    WAY_ZERO  = {AW{1'b0}};
    localparam logic [AW-1:0]    WAY_ONE   = AW'(1);

    state_t              r_state,     w_state_nx;
    logic [CNT_W-1:0]    r_cnt,       w_cnt_nx;
    logic [AW-1:0]       r_way,       w_way_nx;
    logic                r_phase,     w_phase_nx;
    logic                r_from_walk, w_from_walk_nx;
    logic                r_ped,       w_ped_nx;
    logic [3*NWAY-1:0]   r_light,     w_light_nx;
    logic                r_walk,      w_walk_nx;
    logic                w_enter_walk;

    // State, counters and registered lamp outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_ALLRED;
            r_cnt       <= ALLRED_LD;
            r_way       <= LAST_WAY;
            r_phase     <= 1'b1;
            r_from_walk <= 1'b0;
            r_ped       <= 1'b0;
            r_light     <= {NWAY{3'b100}};
            r_walk      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_way       <= w_way_nx;
            r_phase     <= w_phase_nx;
            r_from_walk <= w_from_walk_nx;
            r_ped       <= w_ped_nx;
            r_light     <= w_light_nx;
            r_walk      <= w_walk_nx;
        end
    end

    // Next-state, pedestrian latch and next lamp pattern.
    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_way_nx       = r_way;
        w_phase_nx     = r_phase;
        w_from_walk_nx = r_from_walk;
        w_ped_nx       = r_ped;
        w_light_nx     = {NWAY{3'b100}};
        w_walk_nx      = 1'b0;
        w_enter_walk   = 1'b0;

        if (en) begin
            if (night) begin
                if (r_state != S_FLASH) begin
                    w_state_nx = S_FLASH;
                    w_cnt_nx   = FLASH_LD;
                    w_phase_nx = 1'b1;
                end else if (r_cnt == CNT_ZERO) begin
                    w_phase_nx = ~r_phase;
                    w_cnt_nx   = FLASH_LD;
                end else begin
                    w_cnt_nx   = r_cnt - CNT_ONE;
                end
            end else if ((r_state != S_FLASH) && (r_cnt != CNT_ZERO)) begin
                w_cnt_nx = r_cnt - CNT_ONE;
            end else begin
                case (r_state)
                    S_GREEN: begin
                        w_state_nx = S_YELLOW;
                        w_cnt_nx   = YELLOW_LD;
                    end
                    S_YELLOW: begin
                        w_state_nx     = S_ALLRED;
                        w_cnt_nx       = ALLRED_LD;
                        w_from_walk_nx = 1'b0;
                    end
                    S_ALLRED: begin
                        // A walk is never granted twice in a row.
                        if (r_ped && !r_from_walk) begin
                            w_state_nx = S_WALK;
                            w_cnt_nx   = WALK_LD;
                        end else begin
                            w_state_nx = S_GREEN;
                            w_cnt_nx   = GREEN_LD;
                            w_way_nx   = (r_way == LAST_WAY) ? WAY_ZERO : (r_way + WAY_ONE);
                        end
                    end
                    S_WALK: begin
                        w_state_nx     = S_ALLRED;
                        w_cnt_nx       = ALLRED_LD;
                        w_from_walk_nx = 1'b1;
                    end
                    S_FLASH: begin
                        w_state_nx     = S_ALLRED;
                        w_cnt_nx       = ALLRED_LD;
                        w_from_walk_nx = 1'b0;
                    end
                    default: begin
                        w_state_nx     = S_ALLRED;
                        w_cnt_nx       = ALLRED_LD;
                        w_from_walk_nx = 1'b0;
                    end
                endcase
            end
        end else begin
            w_state_nx = r_state;
        end

        // Request capture runs on every edge, enabled or not.
        w_enter_walk = (w_state_nx == S_WALK) && (r_state != S_WALK);
        if (w_enter_walk) begin
            w_ped_nx = 1'b0;
        end else if (r_state == S_WALK) begin
            w_ped_nx = r_ped;
        end else begin
            w_ped_nx = r_ped | ped_req;
        end

        case (w_state_nx)
            S_GREEN, S_YELLOW: begin
                for (int k = 0; k < NWAY; k++) begin
                    if (w_way_nx == AW'(k)) begin
                        w_light_nx[3*k +: 3] = (w_state_nx == S_GREEN) ? 3'b010 : 3'b001;
                    end else begin
                        w_light_nx[3*k +: 3] = 3'b100;
                    end
                end
            end
            S_FLASH: begin
                w_light_nx = w_phase_nx ? {NWAY{3'b001}} : {NWAY{3'b000}};
            end
            S_WALK: begin
                w_walk_nx = 1'b1;
            end
            S_ALLRED: begin
                w_walk_nx = 1'b0;
            end
            default: begin
                w_walk_nx = 1'b0;
            end
        endcase
    end

    assign light       = r_light;
    assign walk        = r_walk;
    assign active_way  = r_way;
    assign ped_pending = r_ped;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed self-checking bench for traffic_phase_ctrl with short phase timings.
module tb_traffic_phase_ctrl;

    localparam logic [5:0] AR = 6'b100100;
    localparam logic [5:0] G0 = 6'b100010;
    localparam logic [5:0] Y0 = 6'b100001;
    localparam logic [5:0] G1 = 6'b010100;
    localparam logic [5:0] Y1 = 6'b001100;
    localparam logic [5:0] FL_ON  = 6'b001001;
    localparam logic [5:0] FL_OFF = 6'b000000;

    localparam logic [5:0] CYC_L [15] = '{G0, G0, G0, G0, Y0, Y0, AR,
                                          G1, G1, G1, G1, Y1, Y1, AR, G0};
    localparam logic       CYC_W [15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                          1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam logic [5:0] FL_L  [5]  = '{FL_ON, FL_ON, FL_OFF, FL_OFF, FL_ON};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b1;
    logic       night = 1'b0;
    logic       ped_req = 1'b0;
    logic [5:0] light;
    logic       walk;
    logic [0:0] active_way;
    logic       ped_pending;

    int n_pass = 0;
    int n_total = 0;

    traffic_phase_ctrl #(
        .NWAY(2), .CNT_W(8), .GREEN_T(4), .YELLOW_T(2),
        .ALLRED_T(1), .WALK_T(3), .FLASH_T(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .night(night), .ped_req(ped_req),
        .light(light), .walk(walk), .active_way(active_way), .ped_pending(ped_pending)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b1; night = 1'b0; ped_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_total++; if (light !== AR) $display("FAIL reset_light: got %b exp %b", light, AR); else n_pass++;
        n_total++; if (walk !== 1'b0) $display("FAIL reset_walk: got %b exp 0", walk); else n_pass++;
        n_total++; if (active_way !== 1'b1) $display("FAIL reset_way: got %b exp 1", active_way); else n_pass++;
        n_total++; if (ped_pending !== 1'b0) $display("FAIL reset_ped: got %b exp 0", ped_pending); else n_pass++;
        repeat (2) @(negedge clk);
        n_total++; if (light !== AR) $display("FAIL reset_hold_light: got %b exp %b", light, AR); else n_pass++;
    endtask

    task automatic test_cycle();
        do_reset();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            n_total++; if (light !== CYC_L[i]) $display("FAIL cycle_light edge %0d: got %b exp %b", i + 1, light, CYC_L[i]); else n_pass++;
            n_total++; if (active_way !== CYC_W[i]) $display("FAIL cycle_way edge %0d: got %b exp %b", i + 1, active_way, CYC_W[i]); else n_pass++;
            n_total++; if (walk !== 1'b0) $display("FAIL cycle_walk edge %0d: got %b exp 0", i + 1, walk); else n_pass++;
        end
    endtask

    task automatic test_ped_pulse();
        do_reset();
        @(negedge clk);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        n_total++; if (ped_pending !== 1'b1) $display("FAIL ped_latch: got %b exp 1", ped_pending); else n_pass++;
        repeat (5) @(negedge clk);
        n_total++; if (light !== AR || ped_pending !== 1'b1 || walk !== 1'b0)
            $display("FAIL ped_allred: got light %b ped %b walk %b exp %b 1 0", light, ped_pending, walk, AR); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++; if (walk !== 1'b1 || light !== AR || ped_pending !== 1'b0)
                $display("FAIL ped_walk %0d: got walk %b light %b ped %b exp 1 %b 0", i, walk, light, ped_pending, AR); else n_pass++;
        end
        @(negedge clk);
        n_total++; if (walk !== 1'b0 || light !== AR) $display("FAIL ped_post_allred: got walk %b light %b exp 0 %b", walk, light, AR); else n_pass++;
        @(negedge clk);
        n_total++; if (light !== G1 || active_way !== 1'b1) $display("FAIL ped_next_green: got %b way %b exp %b 1", light, active_way, G1); else n_pass++;
    endtask

    task automatic test_ped_hold();
        do_reset();
        ped_req = 1'b1;
        repeat (7) @(negedge clk);
        n_total++; if (ped_pending !== 1'b1) $display("FAIL hold_latched: got %b exp 1", ped_pending); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++; if (walk !== 1'b1 || ped_pending !== 1'b0)
                $display("FAIL hold_walk %0d: got walk %b ped %b exp 1 0", i, walk, ped_pending); else n_pass++;
        end
        @(negedge clk);
        n_total++; if (walk !== 1'b0 || ped_pending !== 1'b0 || light !== AR)
            $display("FAIL hold_exit: got walk %b ped %b light %b exp 0 0 %b", walk, ped_pending, light, AR); else n_pass++;
        @(negedge clk);
        ped_req = 1'b0;
        n_total++; if (ped_pending !== 1'b1 || light !== G1 || walk !== 1'b0)
            $display("FAIL hold_relatch: got ped %b light %b walk %b exp 1 %b 0", ped_pending, light, walk, G1); else n_pass++;
        repeat (7) @(negedge clk);
        n_total++; if (walk !== 1'b1 || ped_pending !== 1'b0)
            $display("FAIL hold_served: got walk %b ped %b exp 1 0", walk, ped_pending); else n_pass++;
    endtask

    task automatic test_enable();
        do_reset();
        repeat (2) @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ped_req = (i == 2) ? 1'b1 : 1'b0;
            @(negedge clk);
            n_total++; if (light !== G0 || active_way !== 1'b0)
                $display("FAIL freeze %0d: got light %b way %b exp %b 0", i, light, active_way, G0); else n_pass++;
        end
        ped_req = 1'b0;
        n_total++; if (ped_pending !== 1'b1) $display("FAIL freeze_ped_capture: got %b exp 1", ped_pending); else n_pass++;
        en = 1'b1;
        @(negedge clk);
        n_total++; if (light !== G0) $display("FAIL resume_g1: got %b exp %b", light, G0); else n_pass++;
        @(negedge clk);
        n_total++; if (light !== G0) $display("FAIL resume_g2: got %b exp %b", light, G0); else n_pass++;
        @(negedge clk);
        n_total++; if (light !== Y0) $display("FAIL resume_yellow: got %b exp %b", light, Y0); else n_pass++;
    endtask

    task automatic test_night();
        do_reset();
        repeat (5) @(negedge clk);
        n_total++; if (light !== Y0) $display("FAIL night_pre_yellow: got %b exp %b", light, Y0); else n_pass++;
        night = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_total++; if (light !== FL_L[i] || walk !== 1'b0)
                $display("FAIL flash %0d: got light %b walk %b exp %b 0", i, light, walk, FL_L[i]); else n_pass++;
        end
        night = 1'b0;
        @(negedge clk);
        n_total++; if (light !== AR || active_way !== 1'b0)
            $display("FAIL night_exit_allred: got %b way %b exp %b 0", light, active_way, AR); else n_pass++;
        @(negedge clk);
        n_total++; if (light !== G1 || active_way !== 1'b1)
            $display("FAIL night_exit_green: got %b way %b exp %b 1", light, active_way, G1); else n_pass++;
    endtask

    task automatic test_reset_mid_walk();
        do_reset();
        @(negedge clk);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        repeat (7) @(negedge clk);
        n_total++; if (walk !== 1'b1) $display("FAIL rstwalk_in_walk: got %b exp 1", walk); else n_pass++;
        ped_req = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (light !== AR || walk !== 1'b0 || ped_pending !== 1'b0 || active_way !== 1'b1)
            $display("FAIL rstwalk_abort: got light %b walk %b ped %b way %b exp %b 0 0 1",
                     light, walk, ped_pending, active_way, AR); else n_pass++;
        @(negedge clk);
        ped_req = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++; if (light !== G0 || active_way !== 1'b0 || ped_pending !== 1'b0)
            $display("FAIL rstwalk_restart: got light %b way %b ped %b exp %b 0 0",
                     light, active_way, ped_pending, G0); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_cycle();
        test_ped_pulse();
        test_ped_hold();
        test_enable();
        test_night();
        test_reset_mid_walk();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/traffic_phase_ctrl.md
TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line; all timing parameters SHALL be >= 1:
 - NWAY, 2, number of road ways served in rotation (>= 2)
 - CNT_W, 8, phase counter width (every *_T SHALL be <= 2^CNT_W)
 - GREEN_T, 10, green duration in clock cycles
 - YELLOW_T, 3, yellow duration in cycles
 - ALLRED_T, 1, all-red clearance duration in cycles
 - WALK_T, 6, pedestrian walk duration in cycles
 - FLASH_T, 4, night-mode half-period in cycles
 - AW, clog2(NWAY) (min 1), width of active_way
REQ-002 Ports (name, direction, width, meaning), one per line:
 - clk, in, 1, single clock, rising edge
 - rst_n, in, 1, reset, asynchronous, active-low
 - en, in, 1, advance enable; low freezes controller
 - night, in, 1, night mode: all ways flash yellow
 - ped_req, in, 1, pedestrian request, level or pulse
 - light, out, 3*NWAY, way k at bits [3k+2:3k] = {R,G,Y}
 - walk, out, 1, pedestrian walk lamp
 - active_way, out, AW, index of the way currently owning green/yellow
 - ped_pending, out, 1, latched, unserved pedestrian request
REQ-003 All outputs SHALL be registered; no combinational input-to-output path.

Function
REQ-004 FSM states: ALLRED, GREEN, YELLOW, WALK, FLASH.
REQ-005 A state of duration T SHALL occupy exactly T enabled clock edges: counter loaded with T-1 on entry, decremented on each enabled edge, transition taken on the edge where it is 0.
REQ-006 Transitions: GREEN->YELLOW; YELLOW->ALLRED; ALLRED->WALK if ped_pending=1 and the previous state was not WALK, otherwise ALLRED->GREEN; WALK->ALLRED.
REQ-007 active_way SHALL increment on ALLRED->GREEN only, wrapping NWAY-1 -> 0.
REQ-008 light: active way = 010 in GREEN, 001 in YELLOW; every other way = 100; all ways = 100 in ALLRED and WALK.
REQ-009 walk SHALL be 1 only in WALK.
REQ-010 ped_pending SHALL be set on any edge with ped_req=1, except while in WALK or on the edge entering WALK (request ignored/consumed). It SHALL clear on the edge entering WALK. Capture SHALL be independent of en and night.
REQ-011 night=1 sampled on an enabled edge SHALL force FLASH from any state. FLASH toggles a phase bit every FLASH_T edges, starting at phase 1. All ways = 001 when phase=1, 000 when phase=0. walk=0.
REQ-012 night=0 while in FLASH SHALL enter ALLRED with a full ALLRED_T count; active_way is unchanged; pending requests are honoured per REQ-006.
REQ-013 en=0 SHALL hold state, counter, flash phase, active_way and all lamp outputs unchanged. night changes are acted on only on enabled edges.
REQ-014 Exactly one way SHALL be non-red at any time outside FLASH; GREEN SHALL never directly follow YELLOW.

Reset
REQ-015 rst_n=0 SHALL immediately force: state=ALLRED, counter=ALLRED_T-1, active_way=NWAY-1, every way 100, walk=0, ped_pending=0, flash phase=1.
REQ-016 After release, the first green SHALL be way 0, after exactly ALLRED_T enabled edges. Reset asserted mid-phase SHALL abort that phase with no residual state.

Verification (NWAY=2, GREEN_T=4, YELLOW_T=2, ALLRED_T=1, WALK_T=3, FLASH_T=2, en=1 unless noted)
REQ-017 Release reset, no requests -> light=100_100 for 1 edge. Then way0 010 for 4 edges, 001 for 2, all-red 1, then way1 green. Period = 14 cycles; active_way alternates 0,1.
REQ-018 One-cycle ped_req during way0 GREEN -> ped_pending=1. After way0 ALLRED: walk=1 for 3 edges with all red and ped_pending=0. Then ALLRED 1 edge, then way1 GREEN.
REQ-019 ped_req held high through WALK -> ignored during WALK and at WALK entry. Re-latched after WALK exits; served at the next ALLRED, never twice in a row.
REQ-020 en=0 for 5 cycles mid-GREEN -> outputs and counter frozen. On resume, the remaining green count completes exactly.
REQ-021 night=1 during YELLOW -> next edge FLASH: all 001 for 2 edges, 000 for 2, repeating. night=0 -> ALLRED 1 edge, then the next way green.
REQ-022 rst_n pulsed low mid-WALK with pending request -> immediate all red, walk=0, ped_pending=0. Sequence restarts per REQ-016.
